// File: rtl/ks_adder_pipe_if.sv
// Streaming handshake bundle for ks_adder_pipe: operand side plus result side.
// The ovf member exists only when KS_ADDER_PIPE_OVF_EN is defined.
interface ks_adder_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] carry;
`ifdef KS_ADDER_PIPE_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, carry
`ifdef KS_ADDER_PIPE_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, carry
`ifdef KS_ADDER_PIPE_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder with valid/ready flow control and per-bit carry export.
// Define KS_ADDER_PIPE_OVF_EN to add the registered signed-overflow output bus.ovf.
module ks_adder_pipe #(
  parameter int WIDTH       = 64,
  parameter int PIPE_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  ks_adder_pipe_if.slave bus
);
  localparam int LV = $clog2(WIDTH);

  // Applies prefix levels lo+1..hi to (g,p); returns the group-propagate or group-generate.
  function automatic logic [WIDTH-1:0] ks_span(input logic [WIDTH-1:0] g_in,
                                               input logic [WIDTH-1:0] p_in,
                                               input int lo, input int hi,
                                               input logic want_p);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    g = g_in;
    p = p_in;
    for (int l = 1; l <= LV; l++) begin
      if (l > lo && l <= hi) begin
        // Descending index so lower bits still hold the previous level when read.
        for (int j = WIDTH - 1; j >= 0; j--) begin
          if (j >= (1 << (l - 1))) begin
            g[j] = g[j] | (p[j] & g[j - (1 << (l - 1))]);
            p[j] = p[j] & p[j - (1 << (l - 1))];
          end
        end
      end
    end
    return want_p ? p : g;
  endfunction

  logic [PIPE_STAGES-1:0] v_reg;
  logic [PIPE_STAGES-1:0] up_v;
  logic [PIPE_STAGES:0]   load;
  logic [WIDTH-1:0]       sum_reg;
  logic [WIDTH-1:0]       carry_reg;
`ifdef KS_ADDER_PIPE_OVF_EN
  logic                   ovf_reg;
`endif

  // Load chain: a rank accepts when empty or when its successor drains it.
  always_comb begin
    load = '0;
    load[PIPE_STAGES] = bus.out_ready;
    for (int r = PIPE_STAGES - 1; r >= 0; r--) begin
      load[r] = !v_reg[r] || load[r + 1];
    end
  end

  always_comb begin
    up_v = '0;
    up_v[0] = bus.in_valid;
    for (int r = 1; r < PIPE_STAGES; r++) begin
      up_v[r] = v_reg[r - 1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_reg <= '0;
    end else begin
      for (int r = 0; r < PIPE_STAGES; r++) begin
        if (load[r]) v_reg[r] <= up_v[r];
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_rank
    localparam int LO = (gi * LV) / PIPE_STAGES;
    localparam int HI = ((gi + 1) * LV) / PIPE_STAGES;
    logic [WIDTH-1:0] src_g;
    logic [WIDTH-1:0] src_p;
    logic [WIDTH-1:0] src_p0;
    logic             src_ci;

    if (gi == 0) begin : g_src
      // cin is merged into bit 0's generate so WIDTH elements suffice for LV levels.
      assign src_p0 = bus.a ^ bus.b;
      assign src_p  = src_p0;
      assign src_g  = (bus.a & bus.b) | {{(WIDTH-1){1'b0}}, src_p0[0] & bus.cin};
      assign src_ci = bus.cin;
    end else begin : g_src
      assign src_g  = g_rank[gi-1].g_mid.g_reg;
      assign src_p  = g_rank[gi-1].g_mid.p_reg;
      assign src_p0 = g_rank[gi-1].g_mid.p0_reg;
      assign src_ci = g_rank[gi-1].g_mid.ci_reg;
    end

    if (gi < PIPE_STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] g_reg;
      logic [WIDTH-1:0] p_reg;
      logic [WIDTH-1:0] p0_reg;
      logic             ci_reg;
      always_ff @(posedge clk) begin
        if (load[gi]) begin
          g_reg  <= ks_span(src_g, src_p, LO, HI, 1'b0);
          p_reg  <= ks_span(src_g, src_p, LO, HI, 1'b1);
          p0_reg <= src_p0;
          ci_reg <= src_ci;
        end
      end
    end else begin : g_out
      logic [WIDTH-1:0] c_fin;
      assign c_fin = ks_span(src_g, src_p, LO, LV, 1'b0);
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sum_reg   <= '0;
          carry_reg <= '0;
`ifdef KS_ADDER_PIPE_OVF_EN
          ovf_reg   <= 1'b0;
`endif
        end else if (load[gi]) begin
          sum_reg   <= src_p0 ^ {c_fin[WIDTH-2:0], src_ci};
          carry_reg <= c_fin;
`ifdef KS_ADDER_PIPE_OVF_EN
          ovf_reg   <= c_fin[WIDTH-2] ^ c_fin[WIDTH-1];
`endif
        end
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = v_reg[PIPE_STAGES-1];
  assign bus.sum       = sum_reg;
  assign bus.carry     = carry_reg;
  assign bus.cout      = carry_reg[WIDTH-1];
`ifdef KS_ADDER_PIPE_OVF_EN
  assign bus.ovf       = ovf_reg;
`endif
endmodule

// File: tb/tb_ks_adder_pipe.sv
// Directed checks of ks_adder_pipe: reset, single adds, stalled streaming, flush, and
// latency/sum checks on two extra width/depth configurations.
module tb_ks_adder_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ks_adder_pipe_if #(.WIDTH(64)) bus ();
  ks_adder_pipe #(.WIDTH(64), .PIPE_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  ks_adder_pipe_if #(.WIDTH(8)) bus8 ();
  ks_adder_pipe #(.WIDTH(8), .PIPE_STAGES(1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  ks_adder_pipe_if #(.WIDTH(33)) bus33 ();
  ks_adder_pipe #(.WIDTH(33), .PIPE_STAGES(7)) dut33 (.clk(clk), .rst_n(rst_n), .bus(bus33));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0;   bus.a = '0;   bus.b = '0;   bus.cin = 0;   bus.out_ready = 1;
    bus8.in_valid = 0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 0;  bus8.out_ready = 1;
    bus33.in_valid = 0; bus33.a = '0; bus33.b = '0; bus33.cin = 0; bus33.out_ready = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    bus.in_valid = 1; bus.a = 64'h5; bus.b = 64'h7;
    repeat (3) step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0 || bus.carry !== '0)
      $display("FAIL reset_outputs: got v=%b sum=%h cout=%b carry=%h expected all 0",
               bus.out_valid, bus.sum, bus.cout, bus.carry);
      else $display("reset_outputs ok");
    if (bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0 || bus.carry !== '0) errors++;
    rst_n = 1;
    bus.in_valid = 0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus8.in_ready !== 1'b1 || bus33.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b/%b expected 1/1/1",
               bus.in_ready, bus8.in_ready, bus33.in_ready);
    end else $display("reset_in_ready ok");
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus8.out_valid !== 1'b0 || bus33.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b/%b/%b expected 0/0/0",
               bus.out_valid, bus8.out_valid, bus33.out_valid);
    end else $display("reset_out_valid ok");
  endtask

  task automatic test_zero();
    bus.a = '0; bus.b = '0; bus.cin = 0; bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_early_valid: got %b expected 0", bus.out_valid);
    end else $display("zero_early_valid ok");
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== '0 || bus.cout !== 1'b0 || bus.carry !== '0) begin
      errors++;
      $display("FAIL zero_result: got v=%b sum=%h cout=%b carry=%h expected v=1 and zeros",
               bus.out_valid, bus.sum, bus.cout, bus.carry);
    end else $display("zero_result ok");
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_drained: got %b expected 0", bus.out_valid);
    end else $display("zero_drained ok");
  endtask

  task automatic test_vectors();
    logic [63:0] ta [4] = '{64'h631ff211631ff211, 64'hffffffffffffffff,
                            64'hffffffffffffffff, 64'h0000000000000001};
    logic [63:0] tb [4] = '{64'h12356312faf2fcff, 64'hffffffff11111111,
                            64'h0000000000000000, 64'h7fffffffffffffff};
    logic        tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] ts [4] = '{64'h755555245e12ef10, 64'hffffffff11111110,
                            64'h0000000000000000, 64'h8000000000000000};
    logic        to [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [63:0] x;
    logic [63:0] exp_carry;
    int          lat;
    for (int k = 0; k < 4; k++) begin
      bus.a = ta[k]; bus.b = tb[k]; bus.cin = tc[k]; bus.in_valid = 1;
      step();
      bus.in_valid = 0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 10) begin
        step();
        lat++;
      end
      x = ta[k] ^ tb[k] ^ ts[k];
      exp_carry = {to[k], x[63:1]};
      checks++;
      if (lat != 2) begin
        errors++;
        $display("FAIL vec%0d_latency: got %0d expected 2", k, lat);
      end else $display("vec%0d_latency ok", k);
      checks++;
      if (bus.sum !== ts[k] || bus.cout !== to[k] || bus.carry !== exp_carry) begin
        errors++;
        $display("FAIL vec%0d_result: got sum=%h cout=%b carry=%h expected sum=%h cout=%b carry=%h",
                 k, bus.sum, bus.cout, bus.carry, ts[k], to[k], exp_carry);
      end else $display("vec%0d_result ok sum=%h cout=%b", k, bus.sum, bus.cout);
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] va [8];
    logic [63:0] vb [8];
    logic        vc [8];
    logic [64:0] exp;
    logic [63:0] x;
    logic [63:0] exp_carry;
    logic [63:0] prev_sum;
    logic [63:0] prev_carry;
    logic        prev_cout;
    bit          stalled_prev = 0;
    int          sent = 0;
    int          got = 0;
    int          ready_low = 0;
    int          extra = 0;
    for (int k = 0; k < 8; k++) begin
      va[k] = {$urandom, $urandom};
      vb[k] = {$urandom, $urandom};
      vc[k] = 1'($urandom_range(1));
    end
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      if (sent < 8) begin
        bus.in_valid = 1; bus.a = va[sent]; bus.b = vb[sent]; bus.cin = vc[sent];
      end else begin
        bus.in_valid = 0;
      end
      #1;
      if (stalled_prev) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.sum !== prev_sum || bus.cout !== prev_cout ||
            bus.carry !== prev_carry) begin
          errors++;
          $display("FAIL stall_hold cyc%0d: got v=%b sum=%h expected v=1 sum=%h",
                   cyc, bus.out_valid, bus.sum, prev_sum);
        end else $display("stall_hold cyc%0d ok", cyc);
      end
      if (bus.in_valid && !bus.in_ready) ready_low++;
      if (bus.out_valid && bus.out_ready) begin
        exp = {1'b0, va[got]} + {1'b0, vb[got]} + {64'd0, vc[got]};
        x = va[got] ^ vb[got] ^ exp[63:0];
        exp_carry = {exp[64], x[63:1]};
        checks++;
        if ({bus.cout, bus.sum} !== exp || bus.carry !== exp_carry) begin
          errors++;
          $display("FAIL stream%0d: got cout=%b sum=%h carry=%h expected cout=%b sum=%h carry=%h",
                   got, bus.cout, bus.sum, bus.carry, exp[64], exp[63:0], exp_carry);
        end else $display("stream%0d ok sum=%h", got, bus.sum);
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      stalled_prev = bus.out_valid && !bus.out_ready;
      prev_sum = bus.sum; prev_cout = bus.cout; prev_carry = bus.carry;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL stream_count: got %0d expected 8", got);
    end else $display("stream_count ok");
    checks++;
    if (ready_low != 4) begin
      errors++;
      $display("FAIL stream_in_ready_low: got %0d cycles expected 4", ready_low);
    end else $display("stream_in_ready_low ok");
    for (int k = 0; k < 5; k++) begin
      if (bus.out_valid === 1'b1) extra++;
      step();
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL stream_no_dup: got %0d extra results expected 0", extra);
    end else $display("stream_no_dup ok");
  endtask

  task automatic test_reset_flush();
    int seen = 0;
    bus.out_ready = 0;
    bus.a = 64'h0123456789abcdef; bus.b = 64'h1111111111111111; bus.cin = 1; bus.in_valid = 1;
    step();
    bus.a = 64'h00000000ffffffff; bus.b = 64'h0000000000000001; bus.cin = 0;
    step();
    rst_n = 0;
    bus.a = 64'h3; bus.b = 64'h4;
    step();
    rst_n = 1;
    bus.in_valid = 0;
    bus.out_ready = 1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0 || bus.carry !== '0 ||
        bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_outputs: got v=%b sum=%h cout=%b carry=%h rdy=%b expected 0/0/0/0/1",
               bus.out_valid, bus.sum, bus.cout, bus.carry, bus.in_ready);
    end else $display("flush_outputs ok");
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_discard: got %0d results expected 0", seen);
    end else $display("flush_discard ok");
  endtask

  task automatic test_ovf();
`ifdef KS_ADDER_PIPE_OVF_EN
    logic [63:0] oa [3] = '{64'h7fffffffffffffff, 64'h0, 64'hffffffffffffffff};
    logic [63:0] ob [3] = '{64'h1, 64'h0, 64'h1};
    logic        oe [3] = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      bus.a = oa[k]; bus.b = ob[k]; bus.cin = 0; bus.in_valid = 1;
      step();
      bus.in_valid = 0;
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.ovf !== oe[k]) begin
        errors++;
        $display("FAIL ovf%0d: got v=%b ovf=%b expected v=1 ovf=%b", k, bus.out_valid, bus.ovf, oe[k]);
      end else $display("ovf%0d ok", k);
      step();
    end
`endif
  endtask

  task automatic test_sweep();
    logic [7:0]  a8, b8;
    logic        c8;
    logic [8:0]  e8;
    logic [32:0] a33, b33;
    logic        c33;
    logic [33:0] e33;
    int          lat;
    for (int k = 0; k < 4; k++) begin
      a8 = (k == 0) ? 8'hff : 8'($urandom);
      b8 = (k == 0) ? 8'h00 : 8'($urandom);
      c8 = (k == 0) ? 1'b1 : 1'($urandom_range(1));
      e8 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
      bus8.a = a8; bus8.b = b8; bus8.cin = c8; bus8.in_valid = 1;
      step();
      bus8.in_valid = 0;
      lat = 1;
      while (bus8.out_valid !== 1'b1 && lat < 20) begin
        step();
        lat++;
      end
      checks++;
      if (lat != 1 || {bus8.cout, bus8.sum} !== e8) begin
        errors++;
        $display("FAIL w8_p1_%0d: got lat=%0d cout/sum=%h expected lat=1 cout/sum=%h",
                 k, lat, {bus8.cout, bus8.sum}, e8);
      end else $display("w8_p1_%0d ok sum=%h", k, bus8.sum);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      a33 = (k == 0) ? 33'h1ffffffff : {1'($urandom_range(1)), 32'($urandom)};
      b33 = (k == 0) ? 33'h000000001 : {1'($urandom_range(1)), 32'($urandom)};
      c33 = (k == 0) ? 1'b0 : 1'($urandom_range(1));
      e33 = {1'b0, a33} + {1'b0, b33} + {33'd0, c33};
      bus33.a = a33; bus33.b = b33; bus33.cin = c33; bus33.in_valid = 1;
      step();
      bus33.in_valid = 0;
      lat = 1;
      while (bus33.out_valid !== 1'b1 && lat < 20) begin
        step();
        lat++;
      end
      checks++;
      if (lat != 7 || {bus33.cout, bus33.sum} !== e33) begin
        errors++;
        $display("FAIL w33_p7_%0d: got lat=%0d cout/sum=%h expected lat=7 cout/sum=%h",
                 k, lat, {bus33.cout, bus33.sum}, e33);
      end else $display("w33_p7_%0d ok sum=%h", k, bus33.sum);
      step();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_zero();
    test_vectors();
    test_back_to_back();
    test_reset_flush();
    test_ovf();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
